// File: rtl/exec_unit_pipe.sv
// Execution unit: single-cycle ALU with writeback bypass, plus load/store through a
// request/response memory port. Counts retired instructions (saturating).
module exec_unit_pipe #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned RADDR_W = 3,
   parameter int unsigned MADDR_W = 8,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         opcode,
   input  logic [RADDR_W-1:0] opa_addr,
   input  logic [RADDR_W-1:0] opb_addr,
   input  logic [RADDR_W-1:0] dest_addr,
   output logic [RADDR_W-1:0] rf_a_addr,
   output logic [RADDR_W-1:0] rf_b_addr,
   input  logic [DATA_W-1:0]  rf_a_data,
   input  logic [DATA_W-1:0]  rf_b_data,
   output logic               mem_req_valid,
   input  logic               mem_req_ready,
   output logic               mem_we,
   output logic [MADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic               mem_rsp_valid,
   input  logic [DATA_W-1:0]  mem_rdata,
   output logic               wb_valid,
   output logic [RADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0]  wb_data,
   output logic               flag_z,
   output logic               flag_c,
   output logic               busy,
   output logic [CNT_W-1:0]   retired
);

   localparam int unsigned SH_W = $clog2(DATA_W);

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_LOAD  = 4'd4;
   localparam logic [3:0] OP_STORE = 4'd5;
   localparam logic [3:0] OP_XOR   = 4'd6;
   localparam logic [3:0] OP_SHL   = 4'd7;
   localparam logic [3:0] OP_SHR   = 4'd8;
   localparam logic [3:0] OP_MOV   = 4'd9;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t              state, state_nxt;
   logic                accept, retire, is_alu, is_mem, alu_c;
   logic [DATA_W-1:0]   opa, opb, alu_res;
   logic [DATA_W:0]     sh_ext;
   logic [SH_W-1:0]     shamt;
   logic [RADDR_W-1:0]  dest_q;

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign accept    = in_valid && in_ready;
   assign rf_a_addr = opa_addr;
   assign rf_b_addr = opb_addr;

   // Forward the writeback in flight so back-to-back dependents see the new value
   assign opa   = (wb_valid && wb_addr == opa_addr) ? wb_data : rf_a_data;
   assign opb   = (wb_valid && wb_addr == opb_addr) ? wb_data : rf_b_data;
   assign shamt = opb[SH_W-1:0];
   assign is_mem = (opcode == OP_LOAD) || (opcode == OP_STORE);

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      is_alu  = 1'b1;
      sh_ext  = '0;
      case (opcode)
         OP_ADD: {alu_c, alu_res} = {1'b0, opa} + {1'b0, opb};
         OP_SUB: {alu_c, alu_res} = {1'b0, opa} - {1'b0, opb};
         OP_AND: alu_res = opa & opb;
         OP_OR:  alu_res = opa | opb;
         OP_XOR: alu_res = opa ^ opb;
         OP_MOV: alu_res = opa;
         // Extra guard bit catches the last bit shifted out (stays 0 for amount 0)
         OP_SHL: begin
            sh_ext = {1'b0, opa} << shamt;
            {alu_c, alu_res} = sh_ext;
         end
         OP_SHR: begin
            sh_ext = {opa, 1'b0} >> shamt;
            {alu_res, alu_c} = sh_ext;
         end
         default: is_alu = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      retire    = 1'b0;
      case (state)
         IDLE: if (accept) begin
            if (is_mem) state_nxt = REQ;
            else        retire    = 1'b1;
         end
         REQ: if (mem_req_ready) begin
            if (mem_we) begin
               state_nxt = IDLE;
               retire    = 1'b1;
            end else begin
               state_nxt = WAIT;
            end
         end
         WAIT: if (mem_rsp_valid) begin
            state_nxt = IDLE;
            retire    = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_req_valid <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         dest_q        <= '0;
         wb_valid      <= 1'b0;
         wb_addr       <= '0;
         wb_data       <= '0;
         flag_z        <= 1'b0;
         flag_c        <= 1'b0;
         retired       <= '0;
      end else begin
         wb_valid <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               if (is_mem) begin
                  mem_req_valid <= 1'b1;
                  mem_we        <= (opcode == OP_STORE);
                  mem_addr      <= opb[MADDR_W-1:0];
                  mem_wdata     <= opa;
                  dest_q        <= dest_addr;
               end else if (is_alu) begin
                  wb_valid <= 1'b1;
                  wb_addr  <= dest_addr;
                  wb_data  <= alu_res;
                  flag_z   <= (alu_res == '0);
                  flag_c   <= alu_c;
               end
            end
            REQ: if (mem_req_ready) mem_req_valid <= 1'b0;
            WAIT: if (mem_rsp_valid) begin
               wb_valid <= 1'b1;
               wb_addr  <= dest_q;
               wb_data  <= mem_rdata;
            end
            default: ;
         endcase
         if (retire && retired != '1) retired <= retired + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Scoreboard bench for exec_unit_pipe: stimulus pushes expected writebacks,
// a negedge monitor pops and compares each wb pulse.
module tb_exec_unit_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  opcode;
   logic [2:0]  opa_addr, opb_addr, dest_addr, rf_a_addr, rf_b_addr;
   logic [7:0]  rf_a_data, rf_b_data;
   logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata;
   logic        wb_valid;
   logic [2:0]  wb_addr;
   logic [7:0]  wb_data;
   logic        flag_z, flag_c, busy;
   logic [15:0] retired;

   logic [7:0]  rf [8];

   typedef struct packed {
      logic [2:0] a;
      logic [7:0] d;
      logic       z;
      logic       c;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   assign rf_a_data = rf[rf_a_addr];
   assign rf_b_data = rf[rf_b_addr];

   exec_unit_pipe dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
      .opa_addr(opa_addr), .opb_addr(opb_addr), .dest_addr(dest_addr),
      .rf_a_addr(rf_a_addr), .rf_b_addr(rf_b_addr),
      .rf_a_data(rf_a_data), .rf_b_data(rf_b_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .flag_z(flag_z), .flag_c(flag_c), .busy(busy), .retired(retired)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic push(input logic [2:0] a, input logic [7:0] d, input logic z, input logic c);
      exp_q.push_back('{a: a, d: d, z: z, c: c});
   endtask

   task automatic send(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] d);
      in_valid  = 1'b1;
      opcode    = op;
      opa_addr  = a;
      opb_addr  = b;
      dest_addr = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Monitor: every writeback pulse must match the oldest expectation
   always @(negedge clk) begin
      if (wb_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_wb: got addr %0d data %0h expected none", wb_addr, wb_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wb_addr", 32'(wb_addr), 32'(mon_e.a));
            chk("wb_data", 32'(wb_data), 32'(mon_e.d));
            chk("flag_z",  32'(flag_z),  32'(mon_e.z));
            chk("flag_c",  32'(flag_c),  32'(mon_e.c));
         end
      end
   end

   initial begin
      reset = 1'b1;  in_valid = 1'b1;  opcode = 4'd0;
      opa_addr = '0; opb_addr = '0; dest_addr = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
      rf[0] = 8'd9;   rf[1] = 8'd0;  rf[2] = 8'd200; rf[3] = 8'd100;
      rf[4] = 8'h81;  rf[5] = 8'd5;  rf[6] = 8'd7;   rf[7] = 8'd1;

      // Reset held with an instruction offered
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_busy",     32'(busy), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_req",      32'(mem_req_valid), 32'd0);
      chk("rst_we",       32'(mem_we), 32'd0);
      chk("rst_addr",     32'(mem_addr), 32'd0);
      chk("rst_wdata",    32'(mem_wdata), 32'd0);
      chk("rst_flags",    32'({flag_z, flag_c}), 32'd0);
      chk("rst_retired",  32'(retired), 32'd0);
      in_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);

      // ADD back-to-back; second operand pair comes only from the bypass (rf[1] stale 0)
      push(3'd1, 8'd44, 1'b0, 1'b1);
      push(3'd4, 8'd88, 1'b0, 1'b0);
      send(4'd0, 3'd2, 3'd3, 3'd1);
      send(4'd0, 3'd1, 3'd1, 3'd4);
      @(negedge clk);
      chk("retired_add", 32'(retired), 32'd2);

      // SUB borrow, SUB zero, SHL/SHR carry-out, XOR, issued back-to-back
      push(3'd7, 8'd254, 1'b0, 1'b1);
      push(3'd2, 8'd0,   1'b1, 1'b0);
      push(3'd3, 8'h02,  1'b0, 1'b1);
      push(3'd5, 8'h40,  1'b0, 1'b1);
      push(3'd1, 8'hAC,  1'b0, 1'b0);
      send(4'd1, 3'd5, 3'd6, 3'd7);
      send(4'd1, 3'd0, 3'd0, 3'd2);
      send(4'd7, 3'd4, 3'd7, 3'd3);
      send(4'd8, 3'd4, 3'd7, 3'd5);
      send(4'd6, 3'd2, 3'd3, 3'd1);
      @(negedge clk);
      chk("retired_alu", 32'(retired), 32'd7);

      // LOAD with 3 stalled request cycles, response two cycles after acceptance
      push(3'd6, 8'h5A, 1'b0, 1'b0);
      send(4'd4, 3'd0, 3'd2, 3'd6);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ld_req_valid", 32'(mem_req_valid), 32'd1);
         chk("ld_we",        32'(mem_we), 32'd0);
         chk("ld_addr",      32'(mem_addr), 32'hC8);
         chk("ld_in_ready",  32'(in_ready), 32'd0);
      end
      mem_req_ready = 1'b1;
      @(posedge clk);
      #1 mem_req_ready = 1'b0;
      @(negedge clk);
      chk("ld_req_drop",  32'(mem_req_valid), 32'd0);
      chk("ld_wait_rdy",  32'(in_ready), 32'd0);
      @(posedge clk);
      #1 mem_rsp_valid = 1'b1; mem_rdata = 8'h5A;
      @(posedge clk);
      #1 mem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("retired_ld", 32'(retired), 32'd8);
      chk("ld_done_rdy", 32'(in_ready), 32'd1);

      // STORE accepted immediately: one-cycle request, no writeback
      rf[1] = 8'h33; rf[7] = 8'h10;
      mem_req_ready = 1'b1;
      send(4'd5, 3'd1, 3'd7, 3'd0);
      @(negedge clk);
      chk("st_req_valid", 32'(mem_req_valid), 32'd1);
      chk("st_we",        32'(mem_we), 32'd1);
      chk("st_addr",      32'(mem_addr), 32'h10);
      chk("st_wdata",     32'(mem_wdata), 32'h33);
      @(negedge clk);
      chk("st_req_drop",  32'(mem_req_valid), 32'd0);
      chk("retired_st",   32'(retired), 32'd9);
      chk("st_in_ready",  32'(in_ready), 32'd1);

      // Reset while waiting for load data, then a late response must be ignored
      send(4'd4, 3'd0, 3'd3, 3'd2);
      @(posedge clk);
      #1 mem_req_ready = 1'b0;
      chk("pre_rst_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_ready", 32'(in_ready), 32'd1);
      chk("midrst_req",   32'(mem_req_valid), 32'd0);
      mem_rsp_valid = 1'b1; mem_rdata = 8'hEE;
      @(posedge clk);
      #1 mem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("late_rsp_wb",  32'(wb_valid), 32'd0);
      chk("late_rsp_ret", 32'(retired), 32'd0);
      chk("late_rsp_idle", 32'(busy), 32'd0);

      // Undefined opcode: retires, no writeback, flags untouched
      push(3'd2, 8'd0, 1'b1, 1'b0);
      send(4'd1, 3'd0, 3'd0, 3'd2);
      send(4'hC, 3'd0, 3'd0, 3'd3);
      @(negedge clk);
      @(negedge clk);
      chk("nop_retired", 32'(retired), 32'd2);
      chk("nop_wb",      32'(wb_valid), 32'd0);
      chk("nop_flags",   32'({flag_z, flag_c}), 32'b10);

      repeat (3) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
